pipeline_perf_counter: RTL

PIPELINE_PERF_COUNTER -- requirements
Module: pipeline_perf_counter

---
 rtl/pipeline_perf_counter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_perf_counter.sv
// Pipeline performance counter: one free-running cycle counter plus N_CH
// event counters, a snapshot shadow bank and a registered read port.
// Optional build macro PERF_SATURATE_EN: counters hold at all-ones instead
// of wrapping (overflow flags behave identically in both builds).
module pipeline_perf_counter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = $clog2(N_CH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             freeze_i,
  input  logic [N_CH-1:0]  event_i,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [N_CH:0]    ovf_o,
  output logic             snap_valid_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q    [N_CH+1];
  logic [CNT_W-1:0] cnt_d    [N_CH+1];
  logic [CNT_W-1:0] shadow_q [N_CH+1];
  logic [CNT_W-1:0] shadow_d [N_CH+1];
  logic [N_CH:0]    ovf_q, ovf_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [N_CH:0]    inc;
  logic             run;

  assign run = (state_q == RUN);

  // Next-state logic; dropping start_i returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (freeze_i) state_d = FROZEN;
        FROZEN:  if (!freeze_i) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Increment requests: cycle counter and registered events, only while running.
  always_comb begin
    inc    = '0;
    inc[0] = run;
    if (run) inc[N_CH:1] = evt_q;
  end

  // Event stage, live counters, overflow flags and snapshot bank next state.
  always_comb begin
    evt_d = run ? event_i : '0;
    if (clear_i) evt_d = '0;
    ovf_d = ovf_q;
    for (int unsigned k = 0; k < N_CH + 1; k++) begin
      cnt_d[k]    = cnt_q[k];
      shadow_d[k] = snap_i ? cnt_q[k] : shadow_q[k];
      if (inc[k]) begin
        if (&cnt_q[k]) begin
          ovf_d[k] = 1'b1;
`ifdef PERF_SATURATE_EN
          cnt_d[k] = cnt_q[k];
`else
          cnt_d[k] = '0;
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
      if (clear_i) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end
    end
    // A snapshot taken together with a clear still leaves the bank valid.
    snap_valid_d = snap_valid_q;
    if (clear_i) snap_valid_d = 1'b0;
    if (snap_i)  snap_valid_d = 1'b1;
  end

  // Read mux; indices beyond the last channel return zero.
  always_comb begin
    rd_data_d = '0;
    for (int unsigned k = 0; k < N_CH + 1; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_data_d = shadow_q[k];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset discards any in-flight event or snapshot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      evt_q        <= '0;
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
      for (int unsigned k = 0; k < N_CH + 1; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      evt_q        <= evt_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_data_d;
      for (int unsigned k = 0; k < N_CH + 1; k++) begin
        cnt_q[k]    <= cnt_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign snap_valid_o = snap_valid_q;
  assign state_o      = state_q;

endmodule
